// File: rtl/dmux16_pkg.sv
// Shared definitions for the two-channel stream demultiplexer.
package dmux16_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int DEPTH_DEF = 2;
  localparam int CNT_W     = 16;

  // Encoding of the sel input: which output channel an input word goes to.
  typedef enum logic {
    CH_A = 1'b0,
    CH_B = 1'b1
  } ch_sel_e;

  // The occupancy counter needs one extra bit so that "full" (== depth) is representable.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dmux16_fifo2.sv
// Small valid/ready FIFO used as one output channel of the demultiplexer.
// When empty, out_data keeps showing the most recently popped word.
module dmux16_fifo2 import dmux16_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [occ_width(DEPTH)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = occ_width(DEPTH);
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             push, pop;

  // Handshake decode and output view; the head word comes straight from storage, so no bypass.
  always_comb begin
    in_ready  = (count_q < FULL_LVL);
    out_valid = (count_q != '0);
    out_data  = out_valid ? mem_q[rd_ptr_q] : last_q;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    count     = count_q;
  end

  // Next-state for storage, pointers (wrapping naturally at DEPTH) and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      last_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Word storage; contents are only visible while counted, so it needs no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Control state, cleared asynchronously so buffered words are discarded on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

endmodule

// File: rtl/dmux16_stream.sv
// Stream demultiplexer: routes each accepted input word to channel a or b,
// each backed by its own FIFO, and counts words accepted per channel.
module dmux16_stream import dmux16_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
);

  localparam int OW = occ_width(DEPTH);
  localparam logic [OW-1:0] FULL_LVL = OW'(DEPTH);

  ch_sel_e          sel_ch;
  logic [OW-1:0]    a_occ, b_occ;
  logic             a_wr_valid, b_wr_valid;
  logic             a_wr_ready, b_wr_ready;
  logic             a_push, b_push;
  logic [CNT_W-1:0] a_count_q, a_count_d;
  logic [CNT_W-1:0] b_count_q, b_count_d;

  // Select decode and in_ready mux; ready looks only at the selected channel's occupancy
  // and is forced low while reset is held.
  always_comb begin
    sel_ch     = ch_sel_e'(sel);
    in_ready   = rst_n && ((sel_ch == CH_B) ? (b_occ < FULL_LVL) : (a_occ < FULL_LVL));
    a_wr_valid = in_valid && in_ready && (sel_ch == CH_A);
    b_wr_valid = in_valid && in_ready && (sel_ch == CH_B);
    a_push     = a_wr_valid && a_wr_ready;
    b_push     = b_wr_valid && b_wr_ready;
  end

  dmux16_fifo2 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in),
    .in_valid  (a_wr_valid),
    .in_ready  (a_wr_ready),
    .out_data  (a_data),
    .out_valid (a_valid),
    .out_ready (a_ready),
    .count     (a_occ)
  );

  dmux16_fifo2 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in),
    .in_valid  (b_wr_valid),
    .in_ready  (b_wr_ready),
    .out_data  (b_data),
    .out_valid (b_valid),
    .out_ready (b_ready),
    .count     (b_occ)
  );

  // Per-channel accept counters, wrapping at 2^16.
  always_comb begin
    a_count_d = a_count_q;
    b_count_d = b_count_q;
    if (a_push) a_count_d = a_count_q + CNT_W'(1);
    if (b_push) b_count_d = b_count_q + CNT_W'(1);
    a_count   = a_count_q;
    b_count   = b_count_q;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_count_q <= '0;
      b_count_q <= '0;
    end else begin
      a_count_q <= a_count_d;
      b_count_q <= b_count_d;
    end
  end

endmodule

// File: tb/tb_dmux16_stream.sv
// Self-checking bench for dmux16_stream: a negedge monitor keeps a reference
// model (per-channel expected-word queues, occupancy, counters) and compares
// every DUT output against it; directed sequences add explicit checks.
module tb_dmux16_stream;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in;
  logic        sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_data;
  logic        a_valid;
  logic        a_ready;
  logic [15:0] b_data;
  logic        b_valid;
  logic        b_ready;
  logic [15:0] a_count;
  logic [15:0] b_count;

  always #5 clk = ~clk;

  dmux16_stream dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in),
    .sel      (sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .a_count  (a_count),
    .b_count  (b_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, owned by the monitor.
  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];
  logic [15:0] cnt_a = '0, cnt_b = '0;
  logic [15:0] last_a = '0, last_b = '0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: actual=%h required=%h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Drive one input cycle: set inputs, let one rising edge pass, return 1 time unit after it.
  task automatic applyStimulus(input logic v, input logic s, input logic [15:0] d);
    in_valid = v;
    sel      = s;
    in       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, sel, in);
  endtask

  // Wait (bounded) for both channels to empty, then confirm they did.
  task automatic drainAll();
    in_valid = 1'b0;
    for (int k = 0; k < 20 && (exp_a.size() != 0 || exp_b.size() != 0); k++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("drain_a", exp_a.size(), 0);
    checkOutput("drain_b", exp_b.size(), 0);
  endtask

  // Monitor: compare outputs to the model mid-cycle, then advance the model for the coming edge.
  always @(negedge clk) begin
    logic exp_rdy;
    if (!rst_n) begin
      exp_a.delete();
      exp_b.delete();
      cnt_a  = '0;
      cnt_b  = '0;
      last_a = '0;
      last_b = '0;
      checkOutput("rst_in_ready", in_ready, 1'b0);
      checkOutput("rst_a_valid", a_valid, 1'b0);
      checkOutput("rst_b_valid", b_valid, 1'b0);
      checkOutput("rst_a_data", a_data, 16'h0);
      checkOutput("rst_b_data", b_data, 16'h0);
      checkOutput("rst_a_count", a_count, 16'h0);
      checkOutput("rst_b_count", b_count, 16'h0);
    end else begin
      exp_rdy = sel ? (exp_b.size() < DEPTH) : (exp_a.size() < DEPTH);
      checkOutput("in_ready", in_ready, exp_rdy);
      checkOutput("a_valid", a_valid, exp_a.size() > 0);
      checkOutput("b_valid", b_valid, exp_b.size() > 0);
      checkOutput("a_data", a_data, (exp_a.size() > 0) ? exp_a[0] : last_a);
      checkOutput("b_data", b_data, (exp_b.size() > 0) ? exp_b[0] : last_b);
      checkOutput("a_count", a_count, cnt_a);
      checkOutput("b_count", b_count, cnt_b);
      if (exp_a.size() > 0 && a_ready) last_a = exp_a.pop_front();
      if (exp_b.size() > 0 && b_ready) last_b = exp_b.pop_front();
      if (in_valid && exp_rdy) begin
        if (sel) begin
          exp_b.push_back(in);
          cnt_b = cnt_b + 16'd1;
        end else begin
          exp_a.push_back(in);
          cnt_a = cnt_a + 16'd1;
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset held with a valid input pending.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    sel      = 1'b0;
    in       = 16'h1111;
    a_ready  = 1'b1;
    b_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready_a", in_ready, 1'b0);
    sel = 1'b1;
    #1;
    checkOutput("reset_in_ready_b", in_ready, 1'b0);
    checkOutput("reset_a_valid", a_valid, 1'b0);
    checkOutput("reset_b_count", b_count, 16'h0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("release_in_ready", in_ready, 1'b1);

    // Routing to each channel, one-cycle latency.
    applyStimulus(1'b1, 1'b1, 16'h1234);
    checkOutput("route_b_valid", b_valid, 1'b1);
    checkOutput("route_b_data", b_data, 16'h1234);
    applyStimulus(1'b1, 1'b0, 16'h9876);
    checkOutput("route_a_valid", a_valid, 1'b1);
    checkOutput("route_a_data", a_data, 16'h9876);
    idleCycles(1);
    checkOutput("route_a_count", a_count, 16'd1);
    checkOutput("route_b_count", b_count, 16'd1);
    checkOutput("empty_b_holds", b_data, 16'h1234);

    // Fill channel a while it is stalled; channel b must stay open.
    a_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 16'hAAAA);
    applyStimulus(1'b1, 1'b0, 16'h5555);
    in_valid = 1'b1;
    sel      = 1'b0;
    in       = 16'h1357;
    #1;
    checkOutput("full_a_refused", in_ready, 1'b0);
    checkOutput("stall_a_data", a_data, 16'hAAAA);
    sel = 1'b1;
    in  = 16'h0F0F;
    #1;
    checkOutput("b_open_while_a_full", in_ready, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("b_not_blocked", b_data, 16'h0F0F);
    // Popping a full FIFO does not make room in the same cycle.
    sel     = 1'b0;
    in      = 16'h1357;
    a_ready = 1'b1;
    #1;
    checkOutput("full_pop_refused", in_ready, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("retry_accept", in_ready, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("push_pop_order", a_data, 16'h1357);
    drainAll();

    // Back-to-back stream through channel a at full rate.
    a_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1;
      sel      = 1'b0;
      in       = 16'(i);
      #1;
      checkOutput("stream_ready", in_ready, 1'b1);
      if (i >= 2) checkOutput("stream_data", a_data, 16'(i - 1));
      @(posedge clk);
      #1;
    end
    checkOutput("stream_last", a_data, 16'h0010);
    drainAll();

    // Reset with two words buffered in channel a: nothing may leak out afterwards.
    a_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 16'hCAFE);
    applyStimulus(1'b1, 1'b0, 16'hBEEF);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkOutput("async_rst_a_valid", a_valid, 1'b0);
    checkOutput("async_rst_a_data", a_data, 16'h0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    a_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      checkOutput("no_leak_a_valid", a_valid, 1'b0);
    end

    // Counter wrap on channel b after 2^16 accepts.
    b_ready = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      if (i == 65535) checkOutput("b_count_max", b_count, 16'hFFFF);
      applyStimulus(1'b1, 1'b1, 16'(i));
    end
    checkOutput("b_count_wrap", b_count, 16'h0);
    checkOutput("a_count_idle", a_count, 16'h0);
    drainAll();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
